// File: rtl/ref_pkg.sv
// ref_pkg: shared FSM states, {cas,ras,we} command codes, A10 index and postpone-threshold clamp for the refresher
package ref_pkg;
  typedef enum logic [2:0] {IDLE, REQ, PRE, WAIT_RP, REF, WAIT_RFC, LAST} ref_state_e;
  localparam logic [2:0] CMD_PRE = 3'b011;
  localparam logic [2:0] CMD_REF = 3'b110;
  localparam int A10 = 10;
  function automatic int post_thr(input int cfg, input int max_p);
    return cfg < 1 ? 1 : cfg > max_p ? max_p : cfg;
  endfunction
endpackage

// File: rtl/ref_trefi_timer.sv
// ref_trefi_timer: tREFI down-counter (clk, rst, en, period in; tick out), one tick every max(period,1) enabled cycles
module ref_trefi_timer #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] period,
  output logic         tick
);
  logic [W-1:0] cnt;
  logic [W-1:0] reload;
  assign reload = period == '0 ? '0 : period - W'(1);
  assign tick = en && cnt == '0;
  always_ff @(posedge clk)
    cnt <= rst || !en || tick ? reload : cnt - W'(1);
endmodule

// File: rtl/refresher_pos_param.sv
// refresher_pos_param: postponing LPDDR4 refresher (sys_clk/sys_rst; cmd_* request port to the mux; ref_* cfg, enable, force in; ref_debt, ref_overflow_err out)
module refresher_pos_param
  import ref_pkg::*;
#(
  parameter int MAX_POSTPONE = 8,
  parameter int TREFI_W      = 12,
  parameter int TRP_W        = 8,
  parameter int TRFC_W       = 8,
  parameter int ADDR_W       = 17,
  parameter int BA_W         = 3,
  parameter int DEBT_W       = $clog2(MAX_POSTPONE + 1)
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic               cmd_last,
  output logic [ADDR_W-1:0]  cmd_payload_a,
  output logic [BA_W-1:0]    cmd_payload_ba,
  output logic               cmd_payload_cas,
  output logic               cmd_payload_ras,
  output logic               cmd_payload_we,
  input  logic [TRP_W-1:0]   ref_tRP_cfg,
  input  logic [TRFC_W-1:0]  ref_tRFC_cfg,
  input  logic [TREFI_W-1:0] ref_tREFI_cfg,
  input  logic [DEBT_W-1:0]  ref_POSTPONE_cfg,
  input  logic               ref_pb_mode_cfg,
  input  logic               ref_enable,
  input  logic               ref_force,
  output logic [DEBT_W-1:0]  ref_debt,
  output logic               ref_overflow_err
);
  localparam int WC_W = TRP_W > TRFC_W ? TRP_W : TRFC_W;
  ref_state_e state, state_n, after_ref;
  logic tick, trig, issue, inc, pb;
  logic [DEBT_W-1:0] debt, sub, left, thr;
  logic [BA_W-1:0] bank;
  logic [TRP_W-1:0] trp_m1;
  logic [TRFC_W-1:0] trfc_m1;
  logic [WC_W-1:0] wcnt;
  ref_trefi_timer #(.W(TREFI_W)) u_timer (
    .clk(sys_clk),
    .rst(sys_rst),
    .en(ref_enable),
    .period(ref_tREFI_cfg),
    .tick(tick)
  );
  always_comb begin
    thr = DEBT_W'(post_thr(int'(ref_POSTPONE_cfg), MAX_POSTPONE));
    trig = (ref_enable && debt >= thr) || ref_force;
    inc = tick && debt != DEBT_W'(MAX_POSTPONE);
    issue = (state == PRE || state == REF) && cmd_ready;
    after_ref = left == DEBT_W'(1) ? LAST : pb ? PRE : REF;
    state_n = state;
    case (state)
      IDLE:     state_n = trig ? REQ : IDLE;
      REQ:      state_n = cmd_ready ? PRE : REQ;
      PRE:      state_n = !cmd_ready ? PRE : trp_m1 == '0 ? REF : WAIT_RP;
      WAIT_RP:  state_n = wcnt == WC_W'(1) ? REF : WAIT_RP;
      REF:      state_n = !cmd_ready ? REF : trfc_m1 == '0 ? after_ref : WAIT_RFC;
      WAIT_RFC: state_n = wcnt == WC_W'(1) ? after_ref : WAIT_RFC;
      default:  state_n = IDLE;
    endcase
    cmd_valid = state != IDLE;
    cmd_last = state == LAST;
    {cmd_payload_cas, cmd_payload_ras, cmd_payload_we} = !issue ? 3'b000 : state == PRE ? CMD_PRE : CMD_REF;
    cmd_payload_a = '0;
    cmd_payload_a[A10] = issue && !pb;
    cmd_payload_ba = issue && pb ? bank : '0;
    ref_debt = debt;
  end
  always_ff @(posedge sys_clk)
    state <= sys_rst ? IDLE : state_n;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      debt <= '0;
      sub <= '0;
      left <= '0;
      bank <= '0;
      pb <= 1'b0;
      trp_m1 <= '0;
      trfc_m1 <= '0;
      wcnt <= '0;
      ref_overflow_err <= 1'b0;
    end else begin
      debt <= debt + DEBT_W'(inc) - (state == LAST ? sub : '0);
      ref_overflow_err <= ref_overflow_err || (tick && !inc);
      if (state == IDLE && trig) begin
        pb <= ref_pb_mode_cfg;
        trp_m1 <= ref_tRP_cfg == '0 ? '0 : ref_tRP_cfg - TRP_W'(1);
        trfc_m1 <= ref_tRFC_cfg == '0 ? '0 : ref_tRFC_cfg - TRFC_W'(1);
        sub <= debt;
        left <= debt == '0 ? DEBT_W'(1) : debt;
      end
      if (state == WAIT_RP || state == WAIT_RFC) wcnt <= wcnt - WC_W'(1);
      if (state == PRE && cmd_ready) wcnt <= WC_W'(trp_m1);
      if (state == REF && cmd_ready) wcnt <= WC_W'(trfc_m1);
      if (state == REF && cmd_ready && pb) bank <= bank + BA_W'(1);
      if (((state == REF && cmd_ready) || state == WAIT_RFC) && (state_n == PRE || state_n == REF))
        left <= left - DEBT_W'(1);
    end
  end
endmodule

// File: tb/tb_refresher_pos_param.sv
// tb_refresher_pos_param: directed bench logging every command/last event and comparing against hand-computed event tables
module tb_refresher_pos_param;
  localparam int K_PRE = 0, K_REF = 1, K_LAST = 2, K_BAD = 3;
  localparam logic [16:0] AB = 17'h00400;
  typedef struct {
    int          cyc;
    int          kind;
    logic [16:0] a;
    logic [2:0]  ba;
  } ev_t;
  logic sys_clk = 1'b0, sys_rst = 1'b1, cmd_ready = 1'b0;
  logic cmd_valid, cmd_last, cmd_payload_cas, cmd_payload_ras, cmd_payload_we, ref_overflow_err;
  logic [16:0] cmd_payload_a;
  logic [2:0] cmd_payload_ba;
  logic [7:0] ref_tRP_cfg = 8'd12, ref_tRFC_cfg = 8'd97;
  logic [11:0] ref_tREFI_cfg = 12'd500;
  logic [3:0] ref_POSTPONE_cfg = 4'd8, ref_debt;
  logic ref_pb_mode_cfg = 1'b0, ref_enable = 1'b1, ref_force = 1'b0;
  int cyc = 0, base = 0, checks = 0, errors = 0;
  ev_t log_q[$];
  ev_t exp_q[$];

  refresher_pos_param #(
    .MAX_POSTPONE(8), .TREFI_W(12), .TRP_W(8), .TRFC_W(8), .ADDR_W(17), .BA_W(3), .DEBT_W(4)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_last(cmd_last),
    .cmd_payload_a(cmd_payload_a), .cmd_payload_ba(cmd_payload_ba),
    .cmd_payload_cas(cmd_payload_cas), .cmd_payload_ras(cmd_payload_ras), .cmd_payload_we(cmd_payload_we),
    .ref_tRP_cfg(ref_tRP_cfg), .ref_tRFC_cfg(ref_tRFC_cfg), .ref_tREFI_cfg(ref_tREFI_cfg),
    .ref_POSTPONE_cfg(ref_POSTPONE_cfg), .ref_pb_mode_cfg(ref_pb_mode_cfg),
    .ref_enable(ref_enable), .ref_force(ref_force),
    .ref_debt(ref_debt), .ref_overflow_err(ref_overflow_err)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    ev_t e;
    if (!sys_rst && (cmd_last || cmd_payload_cas || cmd_payload_ras || cmd_payload_we)) begin
      e.cyc = cyc - base;
      e.kind = cmd_last ? ((cmd_payload_cas | cmd_payload_ras | cmd_payload_we) ? K_BAD : K_LAST)
             : {cmd_payload_cas, cmd_payload_ras, cmd_payload_we} == 3'b011 ? K_PRE
             : {cmd_payload_cas, cmd_payload_ras, cmd_payload_we} == 3'b110 ? K_REF : K_BAD;
      e.a = cmd_payload_a;
      e.ba = cmd_payload_ba;
      log_q.push_back(e);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic at(input int k);
    while (cyc - base < k) @(negedge sys_clk);
  endtask

  task automatic ex(input int c, input int k, input logic [16:0] a, input logic [2:0] ba);
    ev_t e;
    e.cyc = c;
    e.kind = k;
    e.a = a;
    e.ba = ba;
    exp_q.push_back(e);
  endtask

  task automatic cmp_log(input string tag);
    chk({tag, "_events"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk($sformatf("%s_cyc%0d", tag, i), log_q[i].cyc, exp_q[i].cyc);
      chk($sformatf("%s_kind%0d", tag, i), log_q[i].kind, exp_q[i].kind);
      chk($sformatf("%s_a%0d", tag, i), {15'd0, log_q[i].a}, {15'd0, exp_q[i].a});
      chk($sformatf("%s_ba%0d", tag, i), {29'd0, log_q[i].ba}, {29'd0, exp_q[i].ba});
    end
    exp_q.delete();
  endtask

  task automatic do_reset(input int trp, input int trfc, input int trefi, input int post, input logic pb,
                          input logic en, input logic rdy);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    ref_tRP_cfg = 8'(trp);
    ref_tRFC_cfg = 8'(trfc);
    ref_tREFI_cfg = 12'(trefi);
    ref_POSTPONE_cfg = 4'(post);
    ref_pb_mode_cfg = pb;
    ref_enable = en;
    cmd_ready = rdy;
    ref_force = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    base = cyc;
    log_q.delete();
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, cmd_valid, 0);
    chk({tag, "_last"}, cmd_last, 0);
    chk({tag, "_cmd"}, {cmd_payload_cas, cmd_payload_ras, cmd_payload_we}, 0);
    chk({tag, "_a"}, cmd_payload_a, 0);
    chk({tag, "_ba"}, cmd_payload_ba, 0);
    chk({tag, "_debt"}, ref_debt, 0);
    chk({tag, "_ovf"}, ref_overflow_err, 0);
  endtask

  initial begin
    int bad;
    // reset state + all-bank 8-deep burst
    do_reset(12, 97, 500, 8, 1'b0, 1'b1, 1'b1);
    chk_idle_outputs("reset");
    at(499); chk("t1_debt499", ref_debt, 0);
    at(500); chk("t1_debt500", ref_debt, 1);
    at(4000); chk("t1_debt4000", ref_debt, 8); chk("t1_valid4000", cmd_valid, 0);
    at(4001); chk("t1_valid4001", cmd_valid, 1);
    ex(4002, K_PRE, AB, 3'd0);
    for (int i = 0; i < 8; i++) ex(4014 + 97 * i, K_REF, AB, 3'd0);
    ex(4790, K_LAST, 17'd0, 3'd0);
    at(4795);
    cmp_log("t1");
    chk("t1_debt_end", ref_debt, 0);
    chk("t1_ovf_end", ref_overflow_err, 1);
    chk("t1_valid_end", cmd_valid, 0);

    // per-bank, POSTPONE=1, bank pointer wrap
    do_reset(12, 20, 200, 1, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 9; k++) begin
      ex(200 * (k + 1) + 2, K_PRE, 17'd0, 3'(k));
      ex(200 * (k + 1) + 14, K_REF, 17'd0, 3'(k));
      ex(200 * (k + 1) + 34, K_LAST, 17'd0, 3'd0);
    end
    at(1850);
    cmp_log("t2");
    chk("t2_debt_end", ref_debt, 0);

    // cmd_ready held low for 50 cycles after the trigger
    do_reset(5, 9, 100, 1, 1'b0, 1'b1, 1'b0);
    at(100); chk("t3_valid100", cmd_valid, 0);
    bad = 0;
    for (int k = 101; k <= 151; k++) begin
      at(k);
      if (!cmd_valid) bad++;
    end
    chk("t3_stall_valid_low_cycles", bad, 0);
    cmd_ready = 1'b1;
    ex(152, K_PRE, AB, 3'd0);
    ex(157, K_REF, AB, 3'd0);
    ex(166, K_LAST, 17'd0, 3'd0);
    at(180);
    cmp_log("t3");

    // forced unit with enable off and zero debt
    do_reset(5, 9, 100, 8, 1'b0, 1'b0, 1'b1);
    at(10); ref_force = 1'b1;
    at(11); ref_force = 1'b0; chk("t4_valid11", cmd_valid, 1);
    at(20); chk("t4_debt_mid", ref_debt, 0);
    ex(12, K_PRE, AB, 3'd0);
    ex(17, K_REF, AB, 3'd0);
    ex(26, K_LAST, 17'd0, 3'd0);
    at(60);
    cmp_log("t4");
    chk("t4_debt_end", ref_debt, 0);
    chk("t4_valid_end", cmd_valid, 0);

    // saturation and sticky overflow
    do_reset(12, 97, 50, 8, 1'b0, 1'b1, 1'b0);
    at(399); chk("t5_debt399", ref_debt, 7);
    at(400); chk("t5_debt400", ref_debt, 8);
    at(449); chk("t5_ovf449", ref_overflow_err, 0); chk("t5_debt449", ref_debt, 8);
    at(450); chk("t5_ovf450", ref_overflow_err, 1);
    at(500); chk("t5_debt500", ref_debt, 8); chk("t5_ovf500", ref_overflow_err, 1); chk("t5_valid500", cmd_valid, 1);
    at(510); chk("t5_no_cmds", log_q.size(), 0);

    // reset during WAIT_RFC
    do_reset(12, 97, 500, 1, 1'b0, 1'b1, 1'b1);
    at(550);
    chk("t6_debt_before", ref_debt, 1);
    chk("t6_valid_before", cmd_valid, 1);
    ex(502, K_PRE, AB, 3'd0);
    ex(514, K_REF, AB, 3'd0);
    cmp_log("t6pre");
    sys_rst = 1'b1;
    at(551);
    chk_idle_outputs("t6_rst");
    sys_rst = 1'b0;
    base = cyc;
    log_q.delete();
    at(499); chk("t6_debt499", ref_debt, 0);
    at(500); chk("t6_debt500", ref_debt, 1);
    chk("t6_no_events", log_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/refresher_pos_param.md
Name: refresher_pos_param

Overview:
Parametrised refresh controller for the LPDDR4 controller, successor to the fixed 8-deep postponing refresher. Times tREFI, accumulates refresh debt up to a programmable postpone depth, then takes the command path through the refresh-request port of the command multiplexer. It issues precharge and refresh bursts in one of two modes: all-bank (PREA/REFab) or per-bank (PRE/REFpb with a rotating bank pointer). Adds a forced-refresh request, a debt readout and a sticky overflow flag.

Parameters:
MAX_POSTPONE, 8, maximum refresh debt held before forced issue; must be at least 1.
TREFI_W, 12, width of the tREFI config.
TRP_W, 8, width of the tRP config.
TRFC_W, 8, width of the tRFC config.
ADDR_W, 17, width of the command address payload.
BA_W, 3, width of the bank address; NUM_BANKS = 2**BA_W.
DEBT_W, $clog2(MAX_POSTPONE+1), width of the debt and postpone fields.

Ports:
sys_clk  in  1  clock; all logic on rising edge.
sys_rst  in  1  synchronous, active-high reset.
cmd_valid  out  1  refresh request/ownership of the command path.
cmd_ready  in  1  grant from the multiplexer; a command issues only in a cycle where it is 1.
cmd_last  out  1  one-cycle end-of-sequence pulse.
cmd_payload_a  out  ADDR_W  address; only bit 10 is driven (1 = all-bank); other bits are 0.
cmd_payload_ba  out  BA_W  target bank in per-bank mode; 0 in all-bank mode.
cmd_payload_cas  out  1  active-high CAS.
cmd_payload_ras  out  1  active-high RAS.
cmd_payload_we  out  1  active-high WE.
ref_tRP_cfg  in  TRP_W  precharge-to-refresh spacing, in cycles.
ref_tRFC_cfg  in  TRFC_W  refresh-to-next spacing, in cycles (tRFCab or tRFCpb, programmed by software).
ref_tREFI_cfg  in  TREFI_W  tick interval, in cycles.
ref_POSTPONE_cfg  in  DEBT_W  debt threshold that triggers a burst.
ref_pb_mode_cfg  in  1  0 = all-bank, 1 = per-bank.
ref_enable  in  1  gates the timer and new triggers.
ref_force  in  1  pulse; requests one refresh unit immediately.
ref_debt  out  DEBT_W  current debt.
ref_overflow_err  out  1  sticky flag: a tick arrived while debt == MAX_POSTPONE.

Behaviour:
- Reset values: all outputs 0; debt 0; bank pointer 0; FSM in IDLE; timer reloaded with ref_tREFI_cfg.
- Timer: while ref_enable is 1, the timer decrements each cycle. On reaching 0 it produces a one-cycle tick and reloads, so the tick period is exactly ref_tREFI_cfg cycles (0 treated as 1). While ref_enable is 0 the timer holds its reload value and debt is preserved.
- Debt update per cycle: debt_next = debt + tick - (done ? N : 0), where N is the unit count latched at trigger.
  - The increment saturates at MAX_POSTPONE.
  - A tick while debt == MAX_POSTPONE sets ref_overflow_err, which clears only on reset.
  - A simultaneous tick and completion apply both.
- Trigger: in IDLE, go to REQ when either:
  - ref_enable is 1 and debt >= max(ref_POSTPONE_cfg, 1) (a cfg value above MAX_POSTPONE is clamped to MAX_POSTPONE); or
  - ref_force is 1 (ignores ref_enable).
- Unit count at trigger: N = debt, or 1 if debt is 0 (force case). A forced unit with debt 0 leaves debt at 0 on completion (no underflow).
- FSM states: IDLE, REQ, PRE, WAIT_RP, REF, WAIT_RFC, LAST.
  - cmd_valid = 1 in every state except IDLE.
  - REQ -> PRE when cmd_ready is 1.
  - PRE: drive ras=1, we=1, cas=0 for one cycle, issued only when cmd_ready is 1 (otherwise stall in PRE), then go to WAIT_RP.
  - WAIT_RP: wait, then REF; the REF command lands exactly max(tRP,1) cycles after the PRE cycle.
  - REF: drive ras=1, cas=1, we=0 for one cycle (stalls on cmd_ready the same way), then go to WAIT_RFC.
  - WAIT_RFC: after max(tRFC,1) cycles from the REF cycle, either issue the next unit or go to LAST. LAST is reached exactly at REF + tRFC.
  - LAST: assert cmd_last for one cycle with no command (ras/cas/we = 0); this is the completion event. Return to IDLE; cmd_valid is 0 on the next cycle.
- All-bank mode: one PRE with a[10]=1, then N REF commands with a[10]=1, each spaced by tRFC.
- Per-bank mode: each unit is PRE(bank) -> tRP -> REF(bank) -> tRFC with a[10]=0 and ba = bank pointer. The bank pointer increments mod NUM_BANKS after each REF.
- ref_pb_mode_cfg and the timing configs are sampled at the trigger and held for the whole sequence.
- Payload fields are 0 in every cycle with no command.
- sys_rst mid-sequence aborts immediately: no cmd_last is generated and all state returns to reset values.

Decomposition:
- Package ref_pkg holds:
  - the state enum ref_state_e;
  - command encoding constants CMD_PRE and CMD_REF ({cas,ras,we});
  - the A10 bit index;
  - a function for the clamped postpone threshold.
- One sub-module, ref_trefi_timer: tREFI down-counter with enable, producing the tick.

Test Plan:
- Use cfg tRP=12, tRFC=97, tREFI=500, POSTPONE=8, all-bank, cmd_ready=1 from reset release. Required response: ticks at 500, 1000, ... 4000; at the 8th tick cmd_valid rises; PREA (a[10]=1) comes 1 cycle after the REQ grant; 8 REFab commands spaced 97 cycles apart, the first 12 cycles after PREA; cmd_last 97 cycles after the 8th REF; ref_debt returns to 0 (plus any tick that landed during the burst).
- POSTPONE=1, per-bank mode. Required response: each tick gives PRE ba=k, then REF ba=k 12 cycles later, with k = 0..7 then wrap to 0; a[10]=0 throughout.
- Hold cmd_ready=0 for 50 cycles after the trigger, then 1. Required response: cmd_valid stays high, no command is issued, PRE issues the cycle after ready rises, and spacing stays exact.
- ref_enable=0, then ref_force pulse with debt=0. Required response: exactly one PREA plus one REF plus cmd_last; debt stays 0.
- POSTPONE=8, MAX_POSTPONE=8, cmd_ready=0 for 10 tREFI. Required response: ref_debt saturates at 8 and ref_overflow_err is set at the 9th tick and stays set.
- sys_rst pulse during WAIT_RFC. Required response: the next cycle has all outputs 0, no cmd_last, debt 0, and the timer restarts a full 500-cycle period.
